// File: rtl/fp_pkg.sv
// Shared types for the successor filter pipeline: op codes, per-lane config entry, control states.
package fp_pkg;

    localparam int BIT_VEC_SIZE = 128;
    localparam int FP_LANES     = 4;
    localparam int FP_LL        = $clog2(FP_LANES);

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_ANDN = 3'd4,
        OP_NOT  = 3'd5,
        OP_ZERO = 3'd6,
        OP_ONES = 3'd7
    } fp_op_e;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fp_state_e;

    typedef struct packed {
        logic [FP_LL-1:0] sel;
        logic [FP_LL-1:0] opnd;
        fp_op_e           op;
    } fp_cfg_t;

    // Identity entry: output lane l passes input lane l unchanged.
    function automatic fp_cfg_t fp_identity(input int lane);
        fp_cfg_t c;
        c.sel  = FP_LL'(lane);
        c.opnd = FP_LL'(lane);
        c.op   = OP_PASS;
        return c;
    endfunction

endpackage

// File: rtl/fp_stage.sv
// One filter layer: per-lane crossbar picks operands A/B, applies a bitwise op, and registers the beat.
module fp_stage
    import fp_pkg::*;
#(
    parameter int LANES = FP_LANES,
    parameter int W     = BIT_VEC_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  fp_cfg_t [LANES-1:0]    cfg,
    input  logic [LANES*W-1:0]     in_data,
    input  logic                   in_valid,
    input  logic                   advance,
    output logic [LANES*W-1:0]     out_data,
    output logic                   out_valid
);

    logic [W-1:0]         lane_s [LANES];
    logic [W-1:0]         a_s    [LANES];
    logic [W-1:0]         b_s    [LANES];
    logic [LANES*W-1:0]   res_s;
    logic [LANES*W-1:0]   data_r;
    logic                 valid_r;

    // Crossbar operand selection and per-lane bitwise op.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_s[l] = in_data[l*W +: W];
        end
        res_s = {(LANES*W){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            a_s[l] = lane_s[cfg[l].sel];
            b_s[l] = lane_s[cfg[l].opnd];
            case (cfg[l].op)
                OP_PASS: res_s[l*W +: W] = a_s[l];
                OP_AND:  res_s[l*W +: W] = a_s[l] & b_s[l];
                OP_OR:   res_s[l*W +: W] = a_s[l] | b_s[l];
                OP_XOR:  res_s[l*W +: W] = a_s[l] ^ b_s[l];
                OP_ANDN: res_s[l*W +: W] = a_s[l] & ~b_s[l];
                OP_NOT:  res_s[l*W +: W] = ~a_s[l];
                OP_ZERO: res_s[l*W +: W] = {W{1'b0}};
                OP_ONES: res_s[l*W +: W] = {W{1'b1}};
                default: res_s[l*W +: W] = a_s[l];
            endcase
        end
    end

    // Stage register: data only changes when a valid beat moves in, so a stalled beat stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {(LANES*W){1'b0}};
        end else if (advance) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= res_s;
            end
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/fp_pipe.sv
// Successor filter pipeline: STAGES filter layers with valid/ready flow control, shadow/active
// configuration tables committed only once the pipeline has drained, and an output beat counter.
module fp_pipe
    import fp_pkg::*;
#(
    parameter int LANES  = FP_LANES,
    parameter int STAGES = 2,
    parameter int W      = BIT_VEC_SIZE,
    parameter int LL     = $clog2(LANES),
    parameter int SL     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES*W-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cfg_we,
    input  logic [SL-1:0]        cfg_stage,
    input  logic [LL-1:0]        cfg_lane,
    input  logic [LL-1:0]        cfg_sel,
    input  logic [LL-1:0]        cfg_opnd,
    input  logic [2:0]           cfg_op,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic [31:0]          beats_out
);

    fp_cfg_t [STAGES-1:0][LANES-1:0] shadow_r;
    fp_cfg_t [STAGES-1:0][LANES-1:0] shadow_nxt_s;
    fp_cfg_t [STAGES-1:0][LANES-1:0] active_r;
    fp_state_e                       state_r;
    logic                            cfg_busy_r;
    logic [31:0]                     beats_r;
    logic [LANES*W-1:0]              d_s   [STAGES+1];
    logic                            v_s   [STAGES+1];
    logic                            rdy_s [STAGES+1];
    logic                            any_valid_s;

    // Index 0 is the pipeline input (gated while draining); index s+1 is stage s's register.
    assign d_s[0] = in_data;
    assign v_s[0] = in_valid && (state_r == ST_RUN);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        fp_stage #(
            .LANES (LANES),
            .W     (W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .cfg       (active_r[s]),
            .in_data   (d_s[s]),
            .in_valid  (v_s[s]),
            .advance   (rdy_s[s]),
            .out_data  (d_s[s+1]),
            .out_valid (v_s[s+1])
        );
    end

    // Ready ripples back from the consumer; a stage moves when empty or when its successor moves.
    always_comb begin
        for (int s = 0; s <= STAGES; s++) begin
            rdy_s[s] = 1'b0;
        end
        rdy_s[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            rdy_s[s] = !v_s[s+1] || rdy_s[s+1];
        end
    end

    // Drain detector over all stage registers.
    always_comb begin
        any_valid_s = 1'b0;
        for (int s = 1; s <= STAGES; s++) begin
            any_valid_s = any_valid_s | v_s[s];
        end
    end

    // Shadow next-state folds in this cycle's write so a write coincident with the copy is kept.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (cfg_we && (32'(cfg_stage) < 32'(STAGES))) begin
            shadow_nxt_s[cfg_stage][cfg_lane] = '{sel: FP_LL'(cfg_sel), opnd: FP_LL'(cfg_opnd),
                                                  op: fp_op_e'(cfg_op)};
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Shadow table register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    shadow_r[s][l] <= fp_identity(l);
                end
            end
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end

    // Commit FSM: stop intake, wait for every stage to empty, then swap in the shadow table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            cfg_busy_r <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    active_r[s][l] <= fp_identity(l);
                end
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (cfg_commit) begin
                        state_r    <= ST_DRAIN;
                        cfg_busy_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!any_valid_s) begin
                        active_r   <= shadow_nxt_s;
                        state_r    <= ST_RUN;
                        cfg_busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    cfg_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Output handshake counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_r <= 32'd0;
        end else if (v_s[STAGES] && out_ready) begin
            beats_r <= beats_r + 32'd1;
        end
    end

    assign in_ready  = rdy_s[0] && (state_r == ST_RUN);
    assign out_data  = d_s[STAGES];
    assign out_valid = v_s[STAGES];
    assign cfg_busy  = cfg_busy_r;
    assign beats_out = beats_r;

endmodule

// File: tb/tb_fp_pipe.sv
// Scoreboard bench for fp_pipe (LANES=4, STAGES=2, W=128): directed beats with hand-computed results.
module tb_fp_pipe;
    import fp_pkg::*;

    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int W      = 128;
    localparam int DW     = LANES * W;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            cfg_we;
    logic [0:0]      cfg_stage;
    logic [1:0]      cfg_lane;
    logic [1:0]      cfg_sel;
    logic [1:0]      cfg_opnd;
    logic [2:0]      cfg_op;
    logic            cfg_commit;
    logic            cfg_busy;
    logic [31:0]     beats_out;

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [DW-1:0]   sb [$];

    always #5 clk = ~clk;

    fp_pipe #(.LANES(LANES), .STAGES(STAGES), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_stage  (cfg_stage),
        .cfg_lane   (cfg_lane),
        .cfg_sel    (cfg_sel),
        .cfg_opnd   (cfg_opnd),
        .cfg_op     (cfg_op),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .beats_out  (beats_out)
    );

    function automatic logic [DW-1:0] vec(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat until accepted; its expected result joins the scoreboard at acceptance.
    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] exp);
        bit ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                ok = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles");
        end
    endtask

    task automatic cfg_write(input int st, input int ln, input int sl, input int od,
                             input fp_op_e op, input logic commit);
        cfg_we     = 1'b1;
        cfg_stage  = 1'(st);
        cfg_lane   = 2'(ln);
        cfg_sel    = 2'(sl);
        cfg_opnd   = 2'(od);
        cfg_op     = op;
        cfg_commit = commit;
        step();
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic wait_not_busy(input string name);
        for (int i = 0; i < 200 && cfg_busy; i++) step();
        chk32(name, 32'(cfg_busy), 32'd0);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk32(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every output handshake is compared against the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got %h with no beat expected", out_data);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_stage = 1'b0; cfg_lane = 2'd0;
        cfg_sel = 2'd0; cfg_opnd = 2'd0; cfg_op = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk32("reset_out_valid", 32'(out_valid), 32'd0);
        chk32("reset_beats", beats_out, 32'd0);
        chk32("reset_busy", 32'(cfg_busy), 32'd0);
        chk32("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", out_data, {DW{1'b0}});
        step();

        // Identity pass-through with two-cycle latency.
        send(vec(128'h1, 128'h2, 128'h3, 128'h4), vec(128'h1, 128'h2, 128'h3, 128'h4));
        @(negedge clk);
        chk32("t1_valid_after_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk32("t1_valid_after_2", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk32("t1_beats", beats_out, 32'd1);
        step();

        // Ten-beat stream with a five-cycle consumer stall.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(vec(128'(16*i+1), 128'(16*i+2), 128'(16*i+3), 128'(16*i+4)),
                         vec(128'(16*i+1), 128'(16*i+2), 128'(16*i+3), 128'(16*i+4)));
                end
            end
            begin
                repeat (2) step();
                out_ready = 1'b0;
                repeat (3) step();
                @(negedge clk);
                chk32("t3_in_ready_stalled", 32'(in_ready), 32'd0);
                chk32("t3_out_valid_held", 32'(out_valid), 32'd1);
                chk("t3_held_data", out_data, vec(128'h1, 128'h2, 128'h3, 128'h4));
                repeat (2) step();
                out_ready = 1'b1;
            end
        join
        wait_empty("t3_all_out");
        @(negedge clk);
        chk32("t3_beats", beats_out, 32'd11);
        step();

        // Lane swap in stage 0, AND in stage 1.
        cfg_write(0, 0, 1, 0, OP_PASS, 1'b0);
        cfg_write(0, 1, 0, 1, OP_PASS, 1'b0);
        cfg_write(1, 0, 0, 1, OP_AND,  1'b0);
        commit();
        @(negedge clk);
        chk32("t2_busy", 32'(cfg_busy), 32'd1);
        step();
        wait_not_busy("t2_commit_done");
        send(vec(128'hF0, 128'h3C, 128'h55, 128'hAA), vec(128'h30, 128'hF0, 128'h55, 128'hAA));
        wait_empty("t2_out");

        // Commit with beats in flight: old beats see the old table, later beats the new one.
        cfg_write(1, 3, 3, 3, OP_ZERO, 1'b0);
        send(vec(128'h0F, 128'hFF, 128'h12, 128'h34), vec(128'h0F, 128'h0F, 128'h12, 128'h34));
        send(vec(128'hC3, 128'hA5, 128'h66, 128'h77), vec(128'h81, 128'hC3, 128'h66, 128'h77));
        commit();
        @(negedge clk);
        chk32("t4_busy", 32'(cfg_busy), 32'd1);
        chk32("t4_in_ready_drain", 32'(in_ready), 32'd0);
        step();
        send(vec(128'hF0, 128'h3C, 128'h55, 128'hAA), vec(128'h30, 128'hF0, 128'h55, 128'h00));
        wait_empty("t4_out");
        chk32("t4_not_busy", 32'(cfg_busy), 32'd0);

        // Shadow write in the same cycle as commit is part of the copy.
        cfg_write(1, 2, 2, 2, OP_ONES, 1'b1);
        wait_not_busy("t6_commit_done");
        send(vec(128'h1F, 128'h33, 128'h5A, 128'h44), vec(128'h13, 128'h1F, {W{1'b1}}, 128'h00));
        wait_empty("t6_out");

        // Reset with a full pipeline and a stuck commit.
        out_ready = 1'b0;
        send(vec(128'h9, 128'h9, 128'h9, 128'h9), vec(128'h0, 128'h0, 128'h0, 128'h0));
        send(vec(128'h7, 128'h7, 128'h7, 128'h7), vec(128'h0, 128'h0, 128'h0, 128'h0));
        commit();
        step();
        @(negedge clk);
        chk32("t5_busy_stuck", 32'(cfg_busy), 32'd1);
        step();
        rst = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk32("t5_out_valid", 32'(out_valid), 32'd0);
        chk32("t5_beats", beats_out, 32'd0);
        chk32("t5_busy", 32'(cfg_busy), 32'd0);
        chk32("t5_in_ready", 32'(in_ready), 32'd1);
        step();
        send(vec(128'hAB, 128'hCD, 128'hEF, 128'h12), vec(128'hAB, 128'hCD, 128'hEF, 128'h12));
        wait_empty("t5_active_identity");
        commit();
        wait_not_busy("t5_commit_done");
        send(vec(128'h21, 128'h43, 128'h65, 128'h87), vec(128'h21, 128'h43, 128'h65, 128'h87));
        wait_empty("t5_shadow_identity");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
